// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses instruction memory and
// queues {instr, pc} pairs in a 2-entry skid buffer presented to decode via
// valid/ready. Handles sequential fetch, redirect, halt and back-pressure.
module fetch_sequencer #(
   parameter int unsigned addWidth  = 6,
   parameter int unsigned dataWidth = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [addWidth-1:0]  imem_addr,
   input  logic [dataWidth-1:0] imem_data,
   input  logic                 redirect_valid,
   input  logic [addWidth-1:0]  redirect_addr,
   input  logic                 halt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [dataWidth-1:0] out_instr,
   output logic [addWidth-1:0]  out_pc
);

   logic [addWidth-1:0]  pc_q;
   logic [dataWidth-1:0] instr_q [2];
   logic [addWidth-1:0]  epc_q   [2];
   logic                 rd_ptr_q;
   logic                 wr_ptr_q;
   logic [1:0]           count_q;
   logic [1:0]           count_d;
   logic                 pop;
   logic                 push;

   // Handshake decode and occupancy update; redirect flushes regardless of pop.
   always_comb begin
      pop     = out_valid && out_ready;
      push    = !redirect_valid && !halt && ((count_q < 2'd2) || pop);
      count_d = count_q;
      if (redirect_valid) begin
         count_d = 2'd0;
      end else if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   // PC, buffer storage and pointers; pc wraps naturally at 2^addWidth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= '0;
            epc_q[i]   <= '0;
         end
      end else begin
         count_q <= count_d;
         if (redirect_valid) begin
            pc_q     <= redirect_addr;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            if (push) begin
               instr_q[wr_ptr_q] <= imem_data;
               epc_q[wr_ptr_q]   <= pc_q;
               wr_ptr_q          <= ~wr_ptr_q;
               pc_q              <= pc_q + addWidth'(1);
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
         end
      end
   end

   // Outputs come straight from registers, so out_ready never reaches imem_addr.
   always_comb begin
      imem_addr = pc_q;
      out_valid = (count_q != 2'd0);
      out_instr = instr_q[rd_ptr_q];
      out_pc    = epc_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory word k = 0x1000_0000 + k.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [5:0]  redirect_addr;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [5:0]  out_pc;

   int total;
   int bad;

   typedef struct {
      logic       ready;
      logic       rv;
      logic [5:0] ra;
      logic       hlt;
      logic       ev;
      logic [5:0] epc;
      logic [5:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   fetch_sequencer #(.addWidth(6), .dataWidth(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   assign imem_data = 32'h1000_0000 + {26'd0, imem_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic v(input logic r, input logic rv, input logic [5:0] ra, input logic h,
                    input logic ev, input logic [5:0] epc, input logic [5:0] ea);
      vec_t e;
      e.ready = r; e.rv = rv; e.ra = ra; e.hlt = h;
      e.ev = ev; e.epc = epc; e.eaddr = ea;
      vecs.push_back(e);
   endtask

   task automatic check_cycle(input int idx, input vec_t e);
      string tag;
      tag = $sformatf("c%0d", idx);
      check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.ev});
      check({tag, ".imem_addr"}, {26'd0, imem_addr}, {26'd0, e.eaddr});
      if (e.ev) begin
         check({tag, ".out_pc"}, {26'd0, out_pc}, {26'd0, e.epc});
         check({tag, ".out_instr"}, out_instr, 32'h1000_0000 + {26'd0, e.epc});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      halt = 1'b0;

      // sequential fetch
      v(1,0,0,0, 1,0,1);   v(1,0,0,0, 1,1,2);   v(1,0,0,0, 1,2,3);
      // back-pressure: five cycles of ready low starting when out_pc = 3
      v(0,0,0,0, 1,3,4);   v(0,0,0,0, 1,3,5);   v(0,0,0,0, 1,3,5);
      v(0,0,0,0, 1,3,5);   v(0,0,0,0, 1,3,5);
      v(1,0,0,0, 1,3,5);   v(1,0,0,0, 1,4,6);   v(1,0,0,0, 1,5,7);
      v(1,0,0,0, 1,6,8);   v(1,0,0,0, 1,7,9);   v(1,0,0,0, 1,8,10);
      v(1,0,0,0, 1,9,11);
      // redirect to 40 with buffer full (10, 11)
      v(1,1,40,0, 1,10,12); v(1,0,0,0, 0,0,40); v(1,0,0,0, 1,40,41);
      // redirect to 62 and wrap
      v(1,1,62,0, 1,41,42); v(1,0,0,0, 0,0,62); v(1,0,0,0, 1,62,63);
      v(1,0,0,0, 1,63,0);  v(1,0,0,0, 1,0,1);
      // fill one extra entry, then halt for 4 cycles
      v(0,0,0,0, 1,1,2);   v(1,0,0,1, 1,1,3);   v(1,0,0,1, 1,2,3);
      v(1,0,0,1, 0,0,3);   v(1,0,0,1, 0,0,3);   v(1,0,0,0, 0,0,3);
      // resume at held pc 3, then redirect to 20 during halt
      v(1,0,0,1, 1,3,4);   v(1,1,20,1, 0,0,4);  v(1,0,0,1, 0,0,20);
      v(1,0,0,0, 0,0,20);  v(1,0,0,0, 1,20,21); v(1,0,0,0, 1,21,22);

      // reset state
      #8;
      check("rst.valid", {31'd0, out_valid}, 32'd0);
      check("rst.out_pc", {26'd0, out_pc}, 32'd0);
      check("rst.imem_addr", {26'd0, imem_addr}, 32'd0);
      check("rst.out_instr", out_instr, 32'd0);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         check_cycle(i, vecs[i]);
         out_ready      = vecs[i].ready;
         redirect_valid = vecs[i].rv;
         redirect_addr  = vecs[i].ra;
         halt           = vecs[i].hlt;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      halt = 1'b0;

      // asynchronous reset between edges, with a non-empty buffer
      #2 rst_n = 1'b0;
      #1;
      check("arst.valid", {31'd0, out_valid}, 32'd0);
      check("arst.out_pc", {26'd0, out_pc}, 32'd0);
      check("arst.imem_addr", {26'd0, imem_addr}, 32'd0);
      check("arst.out_instr", out_instr, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel.valid", {31'd0, out_valid}, 32'd1);
      check("rel.out_pc", {26'd0, out_pc}, 32'd0);
      check("rel.out_instr", out_instr, 32'h1000_0000);
      @(posedge clk);
      #1;
      check("rel.out_pc1", {26'd0, out_pc}, 32'd1);
      check("rel.imem_addr", {26'd0, imem_addr}, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
